// File: rtl/calc_pkg.sv
// Shared code points and sequencer state encoding for the calc block.
package calc_pkg;

  typedef logic [3:0] cmd_t;

  localparam cmd_t CMD_ADD  = 4'd10;
  localparam cmd_t CMD_SUB  = 4'd11;
  localparam cmd_t CMD_MUL  = 4'd12;
  localparam cmd_t CMD_IDLE = 4'd13;
  localparam cmd_t CMD_EQ   = 4'd14;
  localparam cmd_t CMD_BS   = 4'd15;

  typedef logic [1:0] status_t;

  localparam status_t ST_ERR   = 2'b00;
  localparam status_t ST_BUSY  = 2'b01;
  localparam status_t ST_READY = 2'b10;

  typedef enum logic [1:0] {
    S_RST,
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } seq_state_t;

endpackage

// File: rtl/cmd_fifo.sv
// Circular key FIFO with synchronous flush; pointers wrap naturally at DEPTH.
module cmd_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         data_in,
  output logic [WIDTH-1:0]         data_out,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned FW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (fill == FW'(DEPTH));
  assign empty    = (fill == '0);
  assign do_push  = push && !full && !flush;
  assign do_pop   = pop && !empty && !flush;
  assign data_out = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   fill <= fill + FW'(1);
        2'b01:   fill <= fill - FW'(1);
        default: fill <= fill;
      endcase
    end
  end

  // Storage needs no reset; occupancy gates every read.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= data_in;
  end

endmodule

// File: rtl/calc_cmd_sequencer.sv
// Queues keypad events and hands them to calc one at a time under its
// ready/busy handshake; owns calc's reset, error and timeout recovery.
module calc_cmd_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned RST_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   key_valid,
  input  logic [3:0]             key_code,
  output logic                   key_ready,
  input  logic [1:0]             status,
  output logic [3:0]             cmd,
  output logic                   calc_rst,
  output logic [$clog2(DEPTH):0] fill,
  output logic                   err_flag,
  output logic                   tmo_flag
);

  localparam int unsigned RCW = $clog2(RST_CYCLES + 1);
  localparam int unsigned TCW = $clog2(TIMEOUT + 1);

  seq_state_t     state_q, state_d;
  logic [RCW-1:0] rst_cnt_q, rst_cnt_d;
  logic [TCW-1:0] tmo_cnt_q, tmo_cnt_d;
  cmd_t           cmd_d;
  logic           err_d, tmo_d;
  logic           pop_c, push_c, flush_c, enter_rst_c;
  logic           full, empty;
  logic [3:0]     head;

  assign key_ready = !full && (state_q != S_RST);
  assign push_c    = key_valid && key_ready && (key_code != CMD_IDLE) && !enter_rst_c;
  assign flush_c   = (state_q == S_RST) || enter_rst_c;

  cmd_fifo #(.DEPTH(DEPTH), .WIDTH(4)) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push_c),
    .pop      (pop_c),
    .flush    (flush_c),
    .data_in  (key_code),
    .data_out (head),
    .full     (full),
    .empty    (empty),
    .fill     (fill)
  );

  // Next-state logic; error beats timeout beats handshake progress.
  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    cmd_d       = cmd;
    err_d       = err_flag;
    tmo_d       = tmo_flag;
    pop_c       = 1'b0;
    enter_rst_c = 1'b0;

    unique case (state_q)
      S_RST: begin
        cmd_d = CMD_IDLE;
        if (rst_cnt_q == RCW'(RST_CYCLES - 1)) begin
          state_d   = S_IDLE;
          rst_cnt_d = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + RCW'(1);
        end
      end
      S_IDLE: begin
        cmd_d = CMD_IDLE;
        if (status == ST_READY && !empty) begin
          state_d   = S_ISSUE;
          cmd_d     = head;
          tmo_cnt_d = '0;
        end
      end
      S_ISSUE: begin
        if (tmo_cnt_q == TCW'(TIMEOUT - 1)) begin
          tmo_d       = 1'b1;
          enter_rst_c = 1'b1;
        end else if (status == ST_BUSY) begin
          pop_c     = 1'b1;
          state_d   = S_WAIT;
          tmo_cnt_d = '0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TCW'(1);
        end
      end
      S_WAIT: begin
        if (tmo_cnt_q == TCW'(TIMEOUT - 1)) begin
          tmo_d       = 1'b1;
          enter_rst_c = 1'b1;
        end else if (status == ST_READY) begin
          state_d = S_IDLE;
          cmd_d   = CMD_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TCW'(1);
        end
      end
    endcase

    if (state_q != S_RST && status == ST_ERR) begin
      err_d       = 1'b1;
      tmo_d       = tmo_flag;
      pop_c       = 1'b0;
      enter_rst_c = 1'b1;
    end

    if (enter_rst_c) begin
      state_d   = S_RST;
      rst_cnt_d = '0;
      cmd_d     = CMD_IDLE;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_RST;
      rst_cnt_q <= '0;
      tmo_cnt_q <= '0;
      cmd       <= CMD_IDLE;
      calc_rst  <= 1'b1;
      err_flag  <= 1'b0;
      tmo_flag  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      cmd       <= cmd_d;
      calc_rst  <= (state_d == S_RST);
      err_flag  <= err_d;
      tmo_flag  <= tmo_d;
    end
  end

endmodule
